// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, byte-lane
// select codes and the instruction word width.
package inst_loader_pkg;

   localparam int unsigned INST_W = 32;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      FULL    = 2'd2
   } state_e;

   localparam logic [1:0] LANE_B0 = 2'd0;  // word[7:0]
   localparam logic [1:0] LANE_B1 = 2'd1;  // word[15:8]
   localparam logic [1:0] LANE_B2 = 2'd2;  // word[23:16]
   localparam logic [1:0] LANE_B3 = 2'd3;  // word[31:24]

endpackage

// File: rtl/inst_loader_if.sv
// Instruction RAM write port. The loader drives it through the master modport,
// the RAM (or a bench monitor) observes it through the slave modport.
interface inst_loader_if #(
   parameter int unsigned ADDR_W = 6
);
   import inst_loader_pkg::*;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [INST_W-1:0] mem_wdata;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      input mem_we,
      input mem_addr,
      input mem_wdata
   );

endinterface

// File: rtl/inst_loader_btn_edge.sv
// Button conditioner: optional counter debounce (INST_LOADER_DEBOUNCE_EN)
// followed by a rising-edge detector that emits a single-cycle pulse.
module inst_loader_btn_edge #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic filt;
   logic prev_q;

`ifdef INST_LOADER_DEBOUNCE_EN
   localparam int unsigned          CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             filt_q;
   logic [CNT_W-1:0] cnt_q;

   // Flip the filtered level only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else if (level == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         filt_q <= level;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign filt = filt_q;
`else
   assign filt = level;
`endif

   // Previous-level flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= filt;
      end
   end

   assign rise = filt & ~prev_q;

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory loader: assembles a 32-bit word from four operator-entered
// bytes and writes each completed word to consecutive RAM addresses from 0.
// Optional button debounce is compiled in with INST_LOADER_DEBOUNCE_EN.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          sw,
   input  logic [1:0]          C,
   input  logic                btn_byte,
   input  logic                btn_commit,
   inst_loader_if.master       mem,
   output logic [7:0]          LED,
   output logic [3:0]          lane_valid,
   output logic                full
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_e            state_q, state_d;
   logic [INST_W-1:0] word_q, word_d;
   logic [3:0]        lane_valid_q, lane_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              full_q, full_d;
   logic              we_q;
   logic [ADDR_W-1:0] maddr_q;
   logic [INST_W-1:0] wdata_q;
   logic              byte_rise;
   logic              commit_rise;

   inst_loader_btn_edge #(
      .DB_CYCLES (DB_CYCLES)
   ) u_byte_edge (
      .clk   (clk),
      .rst   (rst),
      .level (btn_byte),
      .rise  (byte_rise)
   );

   inst_loader_btn_edge #(
      .DB_CYCLES (DB_CYCLES)
   ) u_commit_edge (
      .clk   (clk),
      .rst   (rst),
      .level (btn_commit),
      .rise  (commit_rise)
   );

   // Next-state: latch bytes while collecting, one-cycle write, terminal full.
   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      lane_valid_d = lane_valid_q;
      addr_d       = addr_q;
      full_d       = full_q;
      unique case (state_q)
         COLLECT: begin
            // A byte edge wins over a simultaneous commit edge.
            if (byte_rise) begin
               word_d[{C, 3'b000} +: 8] = sw;
               lane_valid_d[C]          = 1'b1;
            end else if (commit_rise && (lane_valid_q == 4'hF)) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            word_d       = '0;
            lane_valid_d = '0;
            if (addr_q == ADDR_MAX) begin
               state_d = FULL;
               full_d  = 1'b1;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = COLLECT;
            end
         end
         FULL: begin
         end
         default: state_d = COLLECT;
      endcase
   end

   // State and registered write-port outputs; strobe coincides with WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= COLLECT;
         word_q       <= '0;
         lane_valid_q <= '0;
         addr_q       <= '0;
         full_q       <= 1'b0;
         we_q         <= 1'b0;
         maddr_q      <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         lane_valid_q <= lane_valid_d;
         addr_q       <= addr_d;
         full_q       <= full_d;
         we_q         <= (state_d == WRITE);
         if (state_d == WRITE) begin
            maddr_q <= addr_q;
            wdata_q <= word_q;
         end
      end
   end

   // LED shows the assembly-register byte selected by C, following C directly.
   always_comb begin
      LED = word_q[7:0];
      unique case (C)
         LANE_B0: LED = word_q[7:0];
         LANE_B1: LED = word_q[15:8];
         LANE_B2: LED = word_q[23:16];
         LANE_B3: LED = word_q[31:24];
      endcase
   end

   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = maddr_q;
   assign mem.mem_wdata = wdata_q;
   assign lane_valid    = lane_valid_q;
   assign full          = full_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus a random phase,
// checked against a lane/address model of the loader's documented behaviour.
module tb_inst_loader;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DBC    = 4;
`ifdef INST_LOADER_DEBOUNCE_EN
   localparam int LAT = DBC;
`else
   localparam int LAT = 0;
`endif
   localparam int EFF  = (LAT > 0) ? LAT : 1;
   localparam int MAXA = (1 << ADDR_W) - 1;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic [1:0] C;
   logic       btn_byte;
   logic       btn_commit;
   logic [7:0] LED;
   logic [3:0] lane_valid;
   logic       full;

   inst_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

   inst_loader #(
      .ADDR_W    (ADDR_W),
      .DB_CYCLES (DBC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw),
      .C          (C),
      .btn_byte   (btn_byte),
      .btn_commit (btn_commit),
      .mem        (mem_if),
      .LED        (LED),
      .lane_valid (lane_valid),
      .full       (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: four byte lanes, their valid flags, next address, full flag.
   logic [7:0] m_lane [4];
   logic [3:0] m_valid;
   int         m_addr;
   bit         m_full;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
      m_valid = 4'h0;
      m_addr  = 0;
      m_full  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; btn_byte = 1'b0; btn_commit = 1'b0; sw = 8'h00; C = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
      chk("rst_mem_we", {31'd0, mem_if.mem_we}, 32'd0);
      chk("rst_mem_addr", {30'd0, mem_if.mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
      chk("rst_led", {24'd0, LED}, 32'd0);
      chk("rst_lane_valid", {28'd0, lane_valid}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
   endtask

   // One operator action: hold the chosen button(s) for 'hold' cycles, then idle.
   task automatic press(input bit do_b, input bit do_c, input logic [1:0] c,
                        input logic [7:0] v, input int hold);
      bit          acts, exp_w;
      logic [3:0]  lv_old, lv_new, exp_lv;
      logic [31:0] exp_word;
      int          exp_addr;
      acts     = (hold >= EFF) && !m_full;
      exp_w    = acts && !do_b && do_c && (m_valid == 4'hF);
      exp_word = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
      exp_addr = m_addr;
      lv_old   = m_valid;
      lv_new   = m_valid;
      if (acts && do_b) lv_new[c] = 1'b1;
      if (exp_w) lv_new = 4'h0;
      @(negedge clk);
      sw = v; C = c; btn_byte = do_b; btn_commit = do_c;
      for (int i = 0; i < hold + LAT + 3; i++) begin
         @(negedge clk);
         chk("mem_we", {31'd0, mem_if.mem_we}, {31'd0, (exp_w && i == LAT)});
         if (exp_w && i == LAT) begin
            chk("mem_addr", {30'd0, mem_if.mem_addr}, exp_addr);
            chk("mem_wdata", mem_if.mem_wdata, exp_word);
         end
         if (do_b) exp_lv = (i < LAT) ? lv_old : lv_new;
         else      exp_lv = (i <= LAT) ? lv_old : lv_new;
         chk("lane_valid", {28'd0, lane_valid}, {28'd0, exp_lv});
         if (i == hold - 1) begin
            btn_byte = 1'b0; btn_commit = 1'b0;
         end
      end
      if (acts && do_b) begin
         m_lane[c] = v; m_valid[c] = 1'b1;
      end else if (exp_w) begin
         for (int j = 0; j < 4; j++) m_lane[j] = 8'h00;
         m_valid = 4'h0;
         if (m_addr == MAXA) m_full = 1'b1;
         else m_addr++;
      end
      chk("full", {31'd0, full}, {31'd0, m_full});
      chk("led", {24'd0, LED}, {24'd0, m_lane[C]});
      C = 2'($urandom_range(0, 3));
      #1;
      chk("led_follow_c", {24'd0, LED}, {24'd0, m_lane[C]});
   endtask

   task automatic fill_word(input logic [31:0] w);
      for (int l = 0; l < 4; l++) press(1'b1, 1'b0, 2'(l), w[8*l +: 8], EFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int h;
      rst = 1'b0; sw = 8'h00; C = 2'd0; btn_byte = 1'b0; btn_commit = 1'b0;
      do_reset();

      // Basic assembly and write at address 0 (held longer than needed).
      press(1'b1, 1'b0, 2'd0, 8'h13, EFF + 1);
      press(1'b1, 1'b0, 2'd1, 8'h00, EFF);
      press(1'b1, 1'b0, 2'd2, 8'h80, EFF + 2);
      press(1'b1, 1'b0, 2'd3, 8'h3C, EFF);
      chk("word_before_commit", {m_lane[3], m_lane[2], m_lane[1], m_lane[0]}, 32'h3C800013);
      press(1'b0, 1'b1, 2'd0, 8'h00, EFF + 2);

      // Incomplete word: commit ignored.
      press(1'b1, 1'b0, 2'd0, 8'hA1, EFF);
      press(1'b1, 1'b0, 2'd1, 8'hB2, EFF);
      press(1'b1, 1'b0, 2'd2, 8'hC3, EFF);
      press(1'b0, 1'b1, 2'd0, 8'h00, EFF);
      chk("partial_lane_valid", {28'd0, lane_valid}, 32'h7);

      // Overwrite lane 1, zero the rest, commit.
      press(1'b1, 1'b0, 2'd1, 8'hAA, EFF);
      press(1'b1, 1'b0, 2'd1, 8'h55, EFF);
      press(1'b1, 1'b0, 2'd0, 8'h00, EFF);
      press(1'b1, 1'b0, 2'd2, 8'h00, EFF);
      press(1'b1, 1'b0, 2'd3, 8'h00, EFF);
      chk("overwrite_word", {m_lane[3], m_lane[2], m_lane[1], m_lane[0]}, 32'h00005500);
      press(1'b0, 1'b1, 2'd0, 8'h00, EFF);

      // Simultaneous byte and commit: byte latched, commit dropped; later commit writes.
      press(1'b1, 1'b0, 2'd0, 8'h11, EFF);
      press(1'b1, 1'b0, 2'd1, 8'h22, EFF);
      press(1'b1, 1'b0, 2'd2, 8'h33, EFF);
      press(1'b1, 1'b1, 2'd3, 8'h44, EFF);
      chk("simul_lane_valid", {28'd0, lane_valid}, 32'hF);
      press(1'b0, 1'b1, 2'd0, 8'h00, EFF);

      // Fill the whole memory, then verify FULL ignores everything.
      do_reset();
      for (int n = 0; n <= MAXA; n++) begin
         fill_word($urandom);
         press(1'b0, 1'b1, 2'd0, 8'h00, EFF);
      end
      chk("full_set", {31'd0, full}, 32'd1);
      fill_word($urandom);
      press(1'b0, 1'b1, 2'd0, 8'h00, EFF);
      chk("full_addr_hold", {30'd0, mem_if.mem_addr}, MAXA);
      chk("full_lane_valid", {28'd0, lane_valid}, 32'd0);

      // Reset while the write strobe is high.
      do_reset();
      fill_word(32'hDEADBEEF);
      @(negedge clk);
      btn_commit = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      chk("rstwr_strobe", {31'd0, mem_if.mem_we}, 32'd1);
      rst = 1'b1; btn_commit = 1'b0;
      @(negedge clk);
      chk("rstwr_we_drop", {31'd0, mem_if.mem_we}, 32'd0);
      chk("rstwr_lane_valid", {28'd0, lane_valid}, 32'd0);
      rst = 1'b0;
      model_clear();
      repeat (LAT + 2) @(negedge clk);
      fill_word(32'h0BADF00D);
      press(1'b0, 1'b1, 2'd0, 8'h00, EFF);

`ifdef INST_LOADER_DEBOUNCE_EN
      // Short glitch is filtered; a longer press latches once after DB cycles.
      press(1'b1, 1'b0, 2'd2, 8'h5A, DBC - 1);
      chk("glitch_ignored", {28'd0, lane_valid}, {28'd0, m_valid});
      press(1'b1, 1'b0, 2'd2, 8'h5A, DBC + 2);
      chk("debounced_latch", {28'd0, lane_valid[2]}, 32'd1);
`endif

      // Random operator activity.
      do_reset();
      for (int n = 0; n < 80; n++) begin
         int  r;
         bit  db, dc;
         if (n == 40) do_reset();
         r  = $urandom_range(0, 3);
         db = (r < 3);
         dc = (r == 3) || ($urandom_range(0, 7) == 0);
         h  = EFF + $urandom_range(0, 2);
         if (LAT > 1 && $urandom_range(0, 9) == 0) h = $urandom_range(1, LAT - 1);
         press(db, dc, 2'($urandom_range(0, 3)), 8'($urandom), h);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
